// File: rtl/rf_pkg.sv
// Shared types and default dimensions for the parametrised register-file bank.
package rf_pkg;

    typedef enum logic {
        RF_IDLE,
        RF_CLEAR
    } rf_state_e;

    localparam int unsigned RF_REGISTER_LEN_DEFAULT = 10;
    localparam int unsigned RF_ADDR_LEN_DEFAULT     = 2;

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: enable-gated load from the array, with optional
// forwarding of a same-edge accepted write to the matching address.
module rf_read_port #(
    parameter int unsigned REGISTER_LEN = 10,
    parameter int unsigned ADDR_LEN     = 2,
    parameter bit          BYPASS       = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [ADDR_LEN-1:0]     addr,
    input  logic [REGISTER_LEN-1:0] mem [2**ADDR_LEN],
    input  logic                    wr_en,
    input  logic [ADDR_LEN-1:0]     wr_addr,
    input  logic [REGISTER_LEN-1:0] wr_data,
    output logic [REGISTER_LEN-1:0] data
);

    logic [REGISTER_LEN-1:0] data_d;
    logic [REGISTER_LEN-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (en) begin
            // wr_en is already qualified by the top (dropped while clearing)
            if (BYPASS && wr_en && (wr_addr == addr)) begin
                data_d = wr_data;
            end else begin
                data_d = mem[addr];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data = data_q;

endmodule

// File: rtl/rf_bank.sv
// 2^ADDR_LEN-entry, 2-read/1-write register file with registered outputs,
// optional write bypass and a one-entry-per-cycle bulk-clear sequencer.
module rf_bank
    import rf_pkg::*;
#(
    parameter int unsigned REGISTER_LEN = RF_REGISTER_LEN_DEFAULT,
    parameter int unsigned ADDR_LEN     = RF_ADDR_LEN_DEFAULT,
    parameter bit          BYPASS       = 1'b1
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic [REGISTER_LEN-1:0] RFIN,
    input  logic                    WE,
    input  logic [ADDR_LEN-1:0]     WA,
    input  logic                    RAE,
    input  logic [ADDR_LEN-1:0]     RAA,
    input  logic                    RBE,
    input  logic [ADDR_LEN-1:0]     RBA,
    input  logic                    CLR,
    output logic                    BUSY,
    output logic [REGISTER_LEN-1:0] A,
    output logic [REGISTER_LEN-1:0] B
);

    localparam int unsigned DEPTH = 2**ADDR_LEN;
    localparam logic [ADDR_LEN-1:0] LAST = ADDR_LEN'(DEPTH - 1);

    logic [REGISTER_LEN-1:0] mem_d [DEPTH];
    logic [REGISTER_LEN-1:0] mem_q [DEPTH];
    rf_state_e               state_d, state_q;
    logic [ADDR_LEN-1:0]     ptr_d, ptr_q;
    logic                    busy_d, busy_q;
    logic                    wr_accept;

    assign wr_accept = WE && (state_q == RF_IDLE);

    always_comb begin
        mem_d   = mem_q;
        state_d = state_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        unique case (state_q)
            RF_IDLE: begin
                if (wr_accept) begin
                    mem_d[WA] = RFIN;
                end
                if (CLR) begin
                    state_d = RF_CLEAR;
                    ptr_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            RF_CLEAR: begin
                mem_d[ptr_q] = '0;
                if (ptr_q == LAST) begin
                    state_d = RF_IDLE;
                    ptr_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: begin
                state_d = RF_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            state_q <= RF_IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

    assign BUSY = busy_q;

    // Ports read mem_q, so an entry being cleared this edge still reads its old value
    rf_read_port #(
        .REGISTER_LEN(REGISTER_LEN),
        .ADDR_LEN    (ADDR_LEN),
        .BYPASS      (BYPASS)
    ) u_port_a (
        .clk    (Clock),
        .rst    (Reset),
        .en     (RAE),
        .addr   (RAA),
        .mem    (mem_q),
        .wr_en  (wr_accept),
        .wr_addr(WA),
        .wr_data(RFIN),
        .data   (A)
    );

    rf_read_port #(
        .REGISTER_LEN(REGISTER_LEN),
        .ADDR_LEN    (ADDR_LEN),
        .BYPASS      (BYPASS)
    ) u_port_b (
        .clk    (Clock),
        .rst    (Reset),
        .en     (RBE),
        .addr   (RBA),
        .mem    (mem_q),
        .wr_en  (wr_accept),
        .wr_addr(WA),
        .wr_data(RFIN),
        .data   (B)
    );

endmodule

// File: tb/tb_rf_bank.sv
// Scoreboard bench: two builds (4x10 bypass, 16x10 no-bypass) share stimulus;
// a behavioural model predicts A/B/BUSY per edge, a negedge monitor compares.
module tb_rf_bank;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [9:0] RFIN  = '0;
    logic       WE    = 1'b0;
    logic [3:0] WA    = '0;
    logic       RAE   = 1'b0;
    logic [3:0] RAA   = '0;
    logic       RBE   = 1'b0;
    logic [3:0] RBA   = '0;
    logic       CLR   = 1'b0;

    logic       busy0, busy1;
    logic [9:0] a0, b0, a1, b1;

    always #5 Clock = ~Clock;

    rf_bank #(.REGISTER_LEN(10), .ADDR_LEN(2), .BYPASS(1'b1)) dut0 (
        .Clock(Clock), .Reset(Reset), .RFIN(RFIN), .WE(WE), .WA(WA[1:0]),
        .RAE(RAE), .RAA(RAA[1:0]), .RBE(RBE), .RBA(RBA[1:0]), .CLR(CLR),
        .BUSY(busy0), .A(a0), .B(b0)
    );

    rf_bank #(.REGISTER_LEN(10), .ADDR_LEN(4), .BYPASS(1'b0)) dut1 (
        .Clock(Clock), .Reset(Reset), .RFIN(RFIN), .WE(WE), .WA(WA),
        .RAE(RAE), .RAA(RAA), .RBE(RBE), .RBA(RBA), .CLR(CLR),
        .BUSY(busy1), .A(a1), .B(b1)
    );

    typedef struct packed {
        logic [9:0] a0, b0, a1, b1;
        logic       y0, y1;
    } exp_t;

    exp_t q[$];
    int unsigned tests  = 0;
    int unsigned errors = 0;

    // Reference model: plain arrays plus a "clear in progress" countdown
    logic [9:0]  m   [2][16];
    int unsigned dep [2] = '{4, 16};
    bit          byp [2] = '{1'b1, 1'b0};
    bit          busy[2];
    int unsigned cp  [2];
    logic [9:0]  ea  [2];
    logic [9:0]  eb  [2];

    task automatic chk(input string name, input int unsigned act, input int unsigned req);
        tests++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) m[d][i] = '0;
            busy[d] = 1'b0;
            cp[d]   = 0;
            ea[d]   = '0;
            eb[d]   = '0;
        end
    endtask

    // Drive one cycle of stimulus (just after negedge) and predict its edge.
    task automatic step(input logic we, input logic [3:0] wa, input logic [9:0] din,
                        input logic rae, input logic [3:0] raa,
                        input logic rbe, input logic [3:0] rba, input logic clr);
        exp_t e;
        @(negedge Clock);
        #1;
        WE = we; WA = wa; RFIN = din; RAE = rae; RAA = raa; RBE = rbe; RBA = rba; CLR = clr;
        for (int d = 0; d < 2; d++) begin
            int unsigned mask = dep[d] - 1;
            int unsigned w    = int'(wa)  & mask;
            int unsigned ra   = int'(raa) & mask;
            int unsigned rb   = int'(rba) & mask;
            bit          fwd  = byp[d] && !busy[d] && we;
            logic [9:0]  na   = rae ? ((fwd && w == ra) ? din : m[d][ra]) : ea[d];
            logic [9:0]  nb   = rbe ? ((fwd && w == rb) ? din : m[d][rb]) : eb[d];
            if (busy[d]) begin
                m[d][cp[d]] = '0;
                cp[d]++;
                if (cp[d] == dep[d]) begin
                    busy[d] = 1'b0;
                    cp[d]   = 0;
                end
            end else begin
                if (we) m[d][w] = din;
                if (clr) begin
                    busy[d] = 1'b1;
                    cp[d]   = 0;
                end
            end
            ea[d] = na;
            eb[d] = nb;
        end
        e.a0 = ea[0]; e.b0 = eb[0]; e.y0 = busy[0];
        e.a1 = ea[1]; e.b1 = eb[1]; e.y1 = busy[1];
        q.push_back(e);
    endtask

    task automatic idle_step();
        step(1'b0, 4'd0, 10'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic read_step(input logic [3:0] ra, input logic [3:0] rb);
        step(1'b0, 4'd0, 10'd0, 1'b1, ra, 1'b1, rb, 1'b0);
    endtask

    task automatic check_zero_now(input string tag);
        chk({tag, "_busy0"}, busy0, 0); chk({tag, "_busy1"}, busy1, 0);
        chk({tag, "_a0"}, a0, 0);       chk({tag, "_b0"}, b0, 0);
        chk({tag, "_a1"}, a1, 0);       chk({tag, "_b1"}, b1, 0);
    endtask

    always @(negedge Clock) begin
        if (!Reset && q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("a0", a0, e.a0);       chk("b0", b0, e.b0);
            chk("busy0", busy0, e.y0);
            chk("a1", a1, e.a1);       chk("b1", b1, e.b1);
            chk("busy1", busy1, e.y1);
        end
    end

    initial begin
        model_reset();
        repeat (2) @(negedge Clock);
        check_zero_now("reset");
        #1 Reset = 1'b0;

        // Reset contents: every entry reads zero on both ports
        for (int i = 0; i < 16; i++) read_step(4'(i), 4'(15 - i));

        // Write then read both ports, then hold with RAE=0
        step(1'b1, 4'd2, 10'h155, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        read_step(4'd2, 4'd2);
        step(1'b0, 4'd0, 10'd0, 1'b0, 4'd1, 1'b0, 4'd1, 1'b0);

        // Same-edge write/read: bypass build forwards, the other returns old data
        step(1'b1, 4'd3, 10'h00A, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        step(1'b1, 4'd3, 10'h3FF, 1'b1, 4'd3, 1'b1, 4'd3, 1'b0);
        read_step(4'd3, 4'd3);

        // Fill, clear with a dropped write during BUSY, then read back
        for (int i = 0; i < 4; i++) step(1'b1, 4'(i), 10'(i + 1), 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 10'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
        step(1'b1, 4'd1, 10'h2AA, 1'b1, 4'd1, 1'b1, 4'd0, 1'b0);
        for (int i = 0; i < 18; i++) read_step(4'(i % 4), 4'(i % 16));

        // Asynchronous reset two cycles into a clear
        for (int i = 0; i < 16; i++) step(1'b1, 4'(i), 10'(i + 7), 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 10'd0, 1'b1, 4'd0, 1'b1, 4'd9, 1'b1);
        read_step(4'd1, 4'd10);
        read_step(4'd2, 4'd11);
        @(negedge Clock);
        #3 Reset = 1'b1;
        #1 check_zero_now("async_reset");
        model_reset();
        q.delete();
        @(negedge Clock);
        #1 Reset = 1'b0;
        for (int i = 0; i < 16; i++) read_step(4'(i), 4'(i));
        step(1'b1, 4'd1, 10'h123, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        read_step(4'd1, 4'd1);

        // Index fill of all 16 entries, reversed readback, full clear
        for (int i = 0; i < 16; i++) step(1'b1, 4'(i), 10'(i), 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        for (int i = 15; i >= 0; i--) read_step(4'(i), 4'(i));
        step(1'b0, 4'd0, 10'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 17; i++) read_step(4'(i % 16), 4'(15 - (i % 16)));

        // Randomised traffic with occasional clears
        for (int n = 0; n < 600; n++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom), 10'($urandom),
                 1'($urandom_range(0, 3) != 0), 4'($urandom),
                 1'($urandom_range(0, 3) != 0), 4'($urandom),
                 1'($urandom_range(0, 29) == 0));
        end

        idle_step();
        repeat (2) @(negedge Clock);
        #2 chk("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/rf_bank.md
# rf_bank

Parametrised successor to the datapath's 4-entry, 2-read/1-write register file. Adds configurable depth (2^ADDR_LEN entries), optional write-to-read bypass, asynchronous reset of all state, and a synchronous bulk-clear sequencer with a busy flag. It sits between the ALU result bus (RFIN) and the operand latches feeding the ALU (A, B), driven by the control unit's enable and address lines.

## Interface
- REGISTER_LEN, 10, data width of every entry and port
- ADDR_LEN, 2, address width; DEPTH = 2^ADDR_LEN entries
- BYPASS, 1, 1 = same-edge write forwarded to a matching read; 0 = read returns pre-write contents
- Clock  input  1  sole clock, all state updates on rising edge
- Reset  input  1  asynchronous, active-high; clears all state immediately
- RFIN  input  REGISTER_LEN  write data
- WE  input  1  write enable
- WA  input  ADDR_LEN  write address
- RAE  input  1  read-port A enable
- RAA  input  ADDR_LEN  read-port A address
- RBE  input  1  read-port B enable
- RBA  input  ADDR_LEN  read-port B address
- CLR  input  1  start bulk clear (sampled, one-cycle pulse sufficient)
- BUSY  output  1  bulk clear in progress
- A  output  REGISTER_LEN  registered read-port A data
- B  output  REGISTER_LEN  registered read-port B data

## Operation
- Reset: every array entry, A, B = 0; BUSY = 0; FSM = IDLE; clear pointer = 0.
- Write: in IDLE, WE=1 at an edge stores RFIN into entry WA.
- Read: RAE=1 at an edge loads A from entry RAA; RAE=0 holds A. Port B identical and independent.
- Bypass (BYPASS=1): if WE=1 and the write is accepted and WA==RAA with RAE=1 at the same edge, A <= RFIN. Same for B. BYPASS=0: A gets the old entry value.
- Both ports may address the same entry; both get identical data.
- FSM IDLE: CLR=1 at an edge -> CLEAR, pointer = 0, BUSY = 1. WE at that same edge is still honoured.
- FSM CLEAR: each edge writes 0 to entry[pointer], pointer++; the edge clearing entry DEPTH-1 -> IDLE, BUSY = 0, pointer = 0.
- In CLEAR: WE ignored (write dropped, no bypass); CLR ignored; reads proceed from array, returning 0 for entries already cleared and pre-clear values otherwise; read of entry[pointer] on its clearing edge returns pre-clear value.
- Pointer width ADDR_LEN; no wrap beyond DEPTH-1.

## Timing
- Read latency 1 cycle: address at edge N, data on A/B after edge N.
- Write visible to a non-bypassed read at edge N+1 or later.
- BUSY rises after the edge sampling CLR, stays high exactly DEPTH cycles, falls after the edge clearing entry DEPTH-1.
- First write accepted at the edge where BUSY is already 0.
- Reset mid-clear: immediate return to IDLE, all entries 0, BUSY 0, regardless of clock.
- Reset deassertion: first active edge is the one after deassertion; no ordering constraint to Clock beyond setup.

## Structure
- Package rf_pkg: state type (RF_IDLE, RF_CLEAR), default REGISTER_LEN/ADDR_LEN constants.
- Sub-module rf_read_port (enable, address, array data, bypass compare, output register) instantiated twice for A and B.
- Array, write logic and clear FSM in rf_bank top.

## Test plan
- Reset then read all entries (DEPTH=4, width 10) -> A=B=0 every read; BUSY=0.
- Write 0x155 to 2, next cycle RAA=RBA=2 -> A=B=0x155; RAE=0 next cycle with RAA=1 -> A holds 0x155.
- BYPASS=1: entry 3=0x00A, same edge WE=1 WA=3 RFIN=0x3FF, RAA=3 RAE=1 -> A=0x3FF; BYPASS=0 build -> A=0x00A.
- Fill entries 0..3 with 1..4, pulse CLR -> BUSY high exactly 4 cycles; WE=1 WA=1 RFIN=0x2AA during BUSY dropped; afterwards all reads 0.
- Assert Reset asynchronously mid-clear after 2 cycles -> BUSY and A/B drop to 0 before next edge; all entries read 0; write after release succeeds.
- ADDR_LEN=4 build: write index to each of 16 entries, read back via both ports in reversed order -> values match; clear takes 16 cycles.
